// File: rtl/conf_cal_pkg.sv
// ---------------------------------------------------------------------------
// conf_cal_pkg
// Shared types and constants for the inverter-strength calibration sequencer.
//   state_t    : sequencer FSM states
//   FLD_*      : index of each configuration field in the code register array
//   NUM_FIELDS : number of configuration fields trimmed per calibration run
// ---------------------------------------------------------------------------
package conf_cal_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        DECIDE = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam int NUM_FIELDS = 4;

    // Search order is field 0 first, then ascending.
    localparam logic [1:0] FLD_UP = 2'd0;  // INVU_PCONF
    localparam logic [1:0] FLD_UN = 2'd1;  // INVU_NCONF
    localparam logic [1:0] FLD_DP = 2'd2;  // INVD_PCONF
    localparam logic [1:0] FLD_DN = 2'd3;  // INVD_NCONF

endpackage

// File: rtl/conf_fb_sync.sv
// ---------------------------------------------------------------------------
// conf_fb_sync
// Two-flop synchroniser for one asynchronous feedback bit.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both flops to 0
//   d   : asynchronous input
//   q   : synchronised output (two clk edges of latency)
// ---------------------------------------------------------------------------
module conf_fb_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/conf_cal_ctrl.sv
// ---------------------------------------------------------------------------
// conf_cal_ctrl
// Closed-loop SAR calibration of the four inverter-strength code fields.
// For each trial bit: wait SETTLE_CYC cycles, collect SAMPLE_CNT samples of
// the synchronised feedback, keep the bit on a strict majority of ones.
//   CLK        : system clock, rising edge
//   RST        : asynchronous active-high reset
//   START      : calibration request (pulse or level), ignored while BUSY
//   O_INVU     : up-inverter feedback (async), steers the INVU fields
//   O_INVD     : down-inverter feedback (async), steers the INVD fields
//   INVU_PCONF : up-inverter P code       INVU_NCONF : up-inverter N code
//   INVD_PCONF : down-inverter P code     INVD_NCONF : down-inverter N code
//   BUSY       : calibration in progress
//   DONE       : calibration complete, held until next START or RST
// ---------------------------------------------------------------------------
module conf_cal_ctrl
    import conf_cal_pkg::*;
#(
    parameter int CONF_BITS  = 4,
    parameter int SETTLE_CYC = 16,
    parameter int SAMPLE_CNT = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 O_INVU,
    input  logic                 O_INVD,
    output logic [CONF_BITS-1:0] INVU_PCONF,
    output logic [CONF_BITS-1:0] INVU_NCONF,
    output logic [CONF_BITS-1:0] INVD_PCONF,
    output logic [CONF_BITS-1:0] INVD_NCONF,
    output logic                 BUSY,
    output logic                 DONE
);

    // One counter width serves both phases; the ones-counter must be able to
    // hold SAMPLE_CNT itself, hence the +1.
    localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CNT + 1) ? SETTLE_CYC : SAMPLE_CNT + 1;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int BW      = (CONF_BITS > 1) ? $clog2(CONF_BITS) : 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CNT - 1);
    localparam logic [CW-1:0] HALF_CNT    = CW'(SAMPLE_CNT / 2);
    localparam logic [BW-1:0] BIT_MSB     = BW'(CONF_BITS - 1);

    state_t                                  state_q, state_d;
    logic [CW-1:0]                           cnt_q, cnt_d;
    logic [CW-1:0]                           ones_q, ones_d;
    logic [1:0]                              fld_q, fld_d;
    logic [BW-1:0]                           bit_q, bit_d;
    logic [NUM_FIELDS-1:0][CONF_BITS-1:0]    code_q, code_d;
    logic                                    busy_q, busy_d;
    logic                                    done_q, done_d;

    logic o_invu_s, o_invd_s;
    logic fb_sel;

    conf_fb_sync u_sync_invu (.clk(CLK), .rst(RST), .d(O_INVU), .q(o_invu_s));
    conf_fb_sync u_sync_invd (.clk(CLK), .rst(RST), .d(O_INVD), .q(o_invd_s));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        fld_d   = fld_q;
        bit_d   = bit_q;
        code_d  = code_q;
        busy_d  = busy_q;
        done_d  = done_q;

        // The two INVU fields are trimmed against the up-inverter, the rest
        // against the down-inverter.
        fb_sel = (fld_q == FLD_UP || fld_q == FLD_UN) ? o_invu_s : o_invd_s;

        unique case (state_q)
            IDLE, FINISH: begin
                if (START) begin
                    code_d                    = '0;
                    code_d[FLD_UP][BIT_MSB]   = 1'b1;
                    fld_d                     = FLD_UP;
                    bit_d                     = BIT_MSB;
                    cnt_d                     = '0;
                    ones_d                    = '0;
                    busy_d                    = 1'b1;
                    done_d                    = 1'b0;
                    state_d                   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (fb_sel) ones_d = ones_q + 1'b1;
                if (cnt_q == SAMPLE_LAST) begin
                    cnt_d   = '0;
                    state_d = DECIDE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECIDE: begin
                ones_d = '0;
                // A tie is treated as "feedback low": the trial bit is dropped.
                if (!(ones_q > HALF_CNT)) code_d[fld_q][bit_q] = 1'b0;
                if (bit_q != '0) begin
                    bit_d                = bit_q - 1'b1;
                    code_d[fld_q][bit_d] = 1'b1;
                    state_d              = SETTLE;
                end else if (fld_q != FLD_DN) begin
                    fld_d                   = fld_q + 2'd1;
                    bit_d                   = BIT_MSB;
                    code_d[fld_d][BIT_MSB]  = 1'b1;
                    state_d                 = SETTLE;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FINISH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ones_q  <= '0;
            fld_q   <= FLD_UP;
            bit_q   <= '0;
            code_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            fld_q   <= fld_d;
            bit_q   <= bit_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign INVU_PCONF = code_q[FLD_UP];
    assign INVU_NCONF = code_q[FLD_UN];
    assign INVD_PCONF = code_q[FLD_DP];
    assign INVD_NCONF = code_q[FLD_DN];
    assign BUSY       = busy_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_conf_cal_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conf_cal_ctrl
// Self-checking bench for conf_cal_ctrl (defaults: 4-bit fields, 16 settle,
// 8 samples). Feedback is produced by a behavioural plant driven from the
// current codes; expected codes come from a plain SAR search model.
// ---------------------------------------------------------------------------
module tb_conf_cal_ctrl;

    logic       CLK = 1'b0;
    logic       RST, START, O_INVU, O_INVD;
    logic [3:0] invu_p, invu_n, invd_p, invd_n;
    logic       busy, done;
    logic [3:0][3:0] codes;

    int errors = 0;
    int checks = 0;

    // Plant configuration: 0 = constant levels, 1 = "code <= target", 2 = toggle
    int              fb_mode = 0;
    logic            cu = 1'b0, cd = 1'b0;
    logic [3:0][3:0] tgt = '0;
    logic            tog = 1'b0;

    conf_cal_ctrl dut (
        .CLK(CLK), .RST(RST), .START(START), .O_INVU(O_INVU), .O_INVD(O_INVD),
        .INVU_PCONF(invu_p), .INVU_NCONF(invu_n),
        .INVD_PCONF(invd_p), .INVD_NCONF(invd_n),
        .BUSY(busy), .DONE(done)
    );

    always #5 CLK = ~CLK;
    always @(negedge CLK) tog <= ~tog;

    assign codes = {invd_n, invd_p, invu_n, invu_p};

    // The N field is zero until its own search starts, so it tells which of
    // the pair is currently being trimmed.
    always_comb begin
        case (fb_mode)
            0: begin
                O_INVU = cu;
                O_INVD = cd;
            end
            1: begin
                O_INVU = (invu_n == 4'h0) ? (invu_p <= tgt[0]) : (invu_n <= tgt[1]);
                O_INVD = (invd_n == 4'h0) ? (invd_p <= tgt[2]) : (invd_n <= tgt[3]);
            end
            default: begin
                O_INVU = tog;
                O_INVD = tog;
            end
        endcase
    end

    typedef struct packed {
        logic [1:0]      mode;
        logic            cu;
        logic            cd;
        logic [3:0][3:0] tgt;
        logic [3:0][3:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference search: try each bit MSB first, keep it if the plant says so.
    function automatic logic [3:0] sar(input int mode, input int f, input logic [3:0] t);
        logic [3:0] code, trial;
        logic       keep;
        code = 4'h0;
        for (int b = 3; b >= 0; b--) begin
            trial = code | (4'h1 << b);
            case (mode)
                0:       keep = (f < 2) ? cu : cd;
                1:       keep = (trial <= t);
                default: keep = 1'b0;
            endcase
            if (keep) code = trial;
        end
        return code;
    endfunction

    // Code visible while bit p is on trial: final bits above p, then the trial bit.
    function automatic logic [3:0] snap(input logic [3:0] v, input int p);
        logic [3:0] m;
        m = 4'hF << (p + 1);
        return (v & m) | (4'h1 << p);
    endfunction

    task automatic run_cal(input int poke_at, input logic [3:0][3:0] fin, input string tag);
        int         n;
        bit         got;
        int         b, f, p;
        logic [3:0] e;
        @(posedge CLK);
        #1 START = 1'b1;
        n   = 0;
        got = 0;
        while (!got && n < 1000) begin
            @(posedge CLK);
            n++;
            #1;
            if (n == 1) START = 1'b0;
            if (poke_at > 0 && n == poke_at) START = 1'b1;
            if (poke_at > 0 && n == poke_at + 1) START = 1'b0;
            @(negedge CLK);
            if ((n - 1) % 25 == 0 && n <= 376) begin
                b = (n - 1) / 25;
                f = b / 4;
                p = 3 - (b % 4);
                for (int i = 0; i < 4; i++) begin
                    e = (i < f) ? fin[i] : (i == f) ? snap(fin[i], p) : 4'h0;
                    chk($sformatf("%s_trial_b%0d_f%0d", tag, b, i), codes[i], e);
                end
                chk($sformatf("%s_busy_b%0d", tag, b), busy, 1'b1);
                chk($sformatf("%s_done_b%0d", tag, b), done, 1'b0);
            end
            if (done) got = 1;
        end
        chk({tag, "_done_edge"}, n, 401);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_final_f%0d", tag, i), codes[i], fin[i]);
        chk({tag, "_busy_end"}, busy, 1'b0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk({tag, "_done_held"}, done, 1'b1);
    endtask

    initial begin
        logic [3:0][3:0] fin;

        vecs[0] = '{mode: 2'd0, cu: 1'b1, cd: 1'b0, tgt: 16'h0000, exp: 16'h00FF};
        vecs[1] = '{mode: 2'd1, cu: 1'b0, cd: 1'b0, tgt: 16'h33AA, exp: 16'h33AA};
        vecs[2] = '{mode: 2'd2, cu: 1'b0, cd: 1'b0, tgt: 16'h0000, exp: 16'h0000};
        vecs[3] = '{mode: 2'd0, cu: 1'b0, cd: 1'b1, tgt: 16'h0000, exp: 16'hFF00};
        vecs[4] = '{mode: 2'd1, cu: 1'b0, cd: 1'b0, tgt: 16'h17F0, exp: 16'h17F0};

        RST   = 1'b1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_codes", codes, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        RST = 1'b0;

        // Table-driven runs; each run after the first restarts from FINISH.
        for (int v = 0; v < 5; v++) begin
            fb_mode = int'(vecs[v].mode);
            cu      = vecs[v].cu;
            cd      = vecs[v].cd;
            tgt     = vecs[v].tgt;
            run_cal(0, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // START while busy must not disturb codes or timing.
        fb_mode = 1;
        tgt     = 16'h33AA;
        run_cal(50, 16'h33AA, "poke");

        // Randomised plants checked against the search model.
        for (int r = 0; r < 6; r++) begin
            fb_mode = (r % 2 == 0) ? 1 : 0;
            tgt     = 16'($urandom);
            cu      = 1'($urandom);
            cd      = 1'($urandom);
            for (int i = 0; i < 4; i++) fin[i] = sar(fb_mode, i, tgt[i]);
            run_cal(0, fin, $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a search.
        fb_mode = 1;
        tgt     = 16'h33AA;
        @(posedge CLK);
        #1 START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (149) @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        chk("midrst_codes", codes, 16'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        @(posedge CLK);
        #1 RST = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk("post_rst_codes", codes, 16'h0);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_done", done, 1'b0);
        run_cal(0, 16'h33AA, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conf_cal_ctrl.md
Name: conf_cal_ctrl

Overview:
Calibration sequencer for the CONF_<N>BITS inverter-strength configuration path. On START it runs a successive-approximation (SAR) search on each of the four configuration fields in turn: INVU_PCONF, INVU_NCONF, INVD_PCONF, INVD_NCONF. For each trial code it waits a settle window, then majority-votes the O_INVU/O_INVD feedback. It holds the final codes and raises DONE, replacing static code loading with closed-loop trimming.

Parameters:
CONF_BITS, 4, width of each configuration field
SETTLE_CYC, 16, cycles waited after each trial-code change before sampling (>=1)
SAMPLE_CNT, 8, feedback samples per decision (power of two, >=2)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-high reset
START  input  1  calibration request; single-cycle pulse or level
O_INVU  input  1  up-inverter feedback, asynchronous to CLK
O_INVD  input  1  down-inverter feedback, asynchronous to CLK
INVU_PCONF  output  CONF_BITS  up-inverter P code
INVU_NCONF  output  CONF_BITS  up-inverter N code
INVD_PCONF  output  CONF_BITS  down-inverter P code
INVD_NCONF  output  CONF_BITS  down-inverter N code
BUSY  output  1  calibration in progress
DONE  output  1  calibration complete; held until next START or RST

Behaviour:
- Reset value of every output is 0: all codes CONF_BITS'h0, BUSY=0, DONE=0. Reset applies immediately, also mid-calibration, and abandons any search in progress.
- Feedback passes through a 2-flop synchroniser; O_INVU_S and O_INVD_S are the only feedback values used. O_INVU_S applies to the INVU fields, O_INVD_S to the INVD fields.
- FSM states: IDLE, SETTLE, SAMPLE, DECIDE, FINISH.
- IDLE or FINISH with START=1: next edge clears all four codes, sets field index=0 and bit index=CONF_BITS-1, and sets the trial bit (MSB) of field 0. BUSY=1, DONE=0, go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE: for SAMPLE_CNT cycles, increment the ones-counter when the selected synchronised feedback is 1, then go to DECIDE.
- DECIDE (1 cycle):
  - Keep the trial bit if ones > SAMPLE_CNT/2 (strict majority); otherwise clear it. A tie clears the bit.
  - Reset the ones-counter.
  - If bit index > 0: decrement it, set the next lower bit of the same field, go to SETTLE.
  - Else if field index < 3: advance to the next field, set its MSB, go to SETTLE.
  - Else go to FINISH with BUSY=0 and DONE=1 on the same edge.
- Each bit costs SETTLE_CYC+SAMPLE_CNT+1 cycles. Total: DONE rises 4*CONF_BITS*(SETTLE_CYC+SAMPLE_CNT+1) edges after the first BUSY edge. With defaults that is 400 edges, or 401 edges after the START-sampling edge.
- Only the field under search changes during calibration. Completed fields hold their values; pending fields stay 0.
- START while BUSY=1 is ignored.
- START in FINISH restarts from scratch: codes are cleared and DONE drops on the next edge.
- Counters size to $clog2(max(SETTLE_CYC,SAMPLE_CNT+1)) bits and never wrap within one phase.

Decomposition:
- Package conf_cal_pkg:
  - state enum (IDLE/SETTLE/SAMPLE/DECIDE/FINISH)
  - field-index constants FLD_UP=0, FLD_UN=1, FLD_DP=2, FLD_DN=3
  - NUM_FIELDS=4
- Sub-module conf_fb_sync: a 2-flop synchroniser, instantiated once per feedback bit, asynchronously reset to 0.
- The FSM, counters and code registers stay in conf_cal_ctrl.

Test Plan:
- Reset: RST=1 at any time, including mid-search at cycle 150 -> all codes 4'h0, BUSY=0, DONE=0 immediately; FSM is in IDLE after release.
- Constant feedback: O_INVU=1, O_INVD=0, START pulse -> BUSY=1 and INVU_PCONF=4'h8 one edge later; final INVU_PCONF=INVU_NCONF=4'hF, INVD_PCONF=INVD_NCONF=4'h0; DONE=1 exactly 401 edges after the START edge.
- Behavioural target model: O_INVU=(field under search <= 4'hA), O_INVD=(field <= 4'h3) -> trial sequence 8,C,A,B for INVU fields; final INVU_*=4'hA, INVD_*=4'h3.
- Tie rule: feedback toggles every cycle during SAMPLE, giving 4/8 ones -> every bit cleared, all codes 4'h0, DONE=1.
- START while BUSY (cycle 50) -> ignored; codes and DONE timing identical to the uninterrupted run.
- Re-run: START with DONE=1 -> DONE drops and codes are 4'h0 (INVU_PCONF=4'h8 trial) on the next edge; the second run reaches the same results as the first.
